// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA 640x480@60 timing constants, framebuffer geometry and pixel type
package vga_pkg;

  // Horizontal timing in pixel clocks
  localparam logic [9:0] H_VISIBLE = 10'd640;
  localparam logic [9:0] H_FP      = 10'd16;
  localparam logic [9:0] H_SYNC    = 10'd96;
  localparam logic [9:0] H_BP      = 10'd48;
  localparam logic [9:0] H_TOTAL   = 10'd800;

  // Vertical timing in lines
  localparam logic [9:0] V_VISIBLE = 10'd480;
  localparam logic [9:0] V_FP      = 10'd10;
  localparam logic [9:0] V_SYNC    = 10'd2;
  localparam logic [9:0] V_BP      = 10'd33;
  localparam logic [9:0] V_TOTAL   = 10'd525;

  // Sync window bounds derived from the porch widths
  localparam logic [9:0] H_SYNC_START = H_VISIBLE + H_FP;
  localparam logic [9:0] H_SYNC_END   = H_VISIBLE + H_FP + H_SYNC;
  localparam logic [9:0] V_SYNC_START = V_VISIBLE + V_FP;
  localparam logic [9:0] V_SYNC_END   = V_VISIBLE + V_FP + V_SYNC;

  // Framebuffer geometry
  localparam int FB_WIDTH  = 160;
  localparam int FB_HEIGHT = 120;

  // One framebuffer pixel: {R,G,B}
  typedef logic [2:0] pixel_t;

  // Test-pattern bar index: eight 80-pixel-wide vertical bars
  function automatic pixel_t bar_colour(input logic [9:0] h);
    pixel_t bar;
    bar = '0;
    for (int i = 1; i < 8; i++) begin
      if (h >= 10'(80 * i)) bar = pixel_t'(i);
    end
    return bar;
  endfunction

endpackage

// File: rtl/vga_scanout_if.sv
// rtl/vga_scanout_if.sv - synchronous-read framebuffer port between scanout and RAM
interface vga_scanout_if #(
  parameter int FB_ADDR_W = 15
);
  import vga_pkg::*;

  logic [FB_ADDR_W-1:0] fb_addr;
  pixel_t               fb_data;

  // Scanout drives the address and consumes data one clock later
  modport master (output fb_addr, input fb_data);
  // RAM side
  modport slave  (input fb_addr, output fb_data);
endinterface

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - pixel enable, h/v counters, sync/blank decode and frame pulse
module vga_timing (
  input  logic       clock,
  input  logic       resetn,
  output logic       pix_en,
  output logic [9:0] h,
  output logic [9:0] v,
  output logic       visible,
  output logic       hs_n,
  output logic       vs_n,
  output logic       frame_start
);
  import vga_pkg::*;

  logic h_last;
  logic v_last;

  assign h_last = (h == H_TOTAL - 10'd1);
  assign v_last = (v == V_TOTAL - 10'd1);

  // Divide-by-2 pixel enable; a rising edge with pix_en high advances the raster
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) pix_en <= 1'b0;
    else         pix_en <= ~pix_en;
  end

  // Raster position: h wraps at end of line and carries into v
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      h <= '0;
      v <= '0;
    end else if (pix_en) begin
      if (h_last) begin
        h <= '0;
        v <= v_last ? 10'd0 : v + 10'd1;
      end else begin
        h <= h + 10'd1;
      end
    end
  end

  // Sync and visible decode of the current position (registered downstream)
  always_comb begin
    visible = (h < H_VISIBLE) && (v < V_VISIBLE);
    hs_n    = !((h >= H_SYNC_START) && (h < H_SYNC_END));
    vs_n    = !((v >= V_SYNC_START) && (v < V_SYNC_END));
  end

  // Single-clock pulse on the advance edge that wraps the raster back to (0,0)
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) frame_start <= 1'b0;
    else         frame_start <= pix_en && h_last && v_last;
  end

endmodule

// File: rtl/vga_scanout.sv
// rtl/vga_scanout.sv - framebuffer scanout to VGA DAC; SCANOUT_TESTPAT_EN selects colour bars
module vga_scanout #(
  parameter int H_SCALE_LOG2 = 2,
  parameter int FB_WIDTH     = 160,
  parameter int FB_ADDR_W    = 15
) (
  input  logic              clock,
  input  logic              resetn,
  vga_scanout_if.master     fb,
  output logic              VGA_CLK,
  output logic              VGA_HS,
  output logic              VGA_VS,
  output logic              VGA_BLANK_N,
  output logic              VGA_SYNC_N,
  output logic [9:0]        VGA_R,
  output logic [9:0]        VGA_G,
  output logic [9:0]        VGA_B,
  output logic              frame_start
);
  import vga_pkg::*;

  logic       pix_en;
  logic [9:0] h;
  logic [9:0] v;
  logic       visible;
  logic       hs_n;
  logic       vs_n;

  vga_timing u_timing (
    .clock       (clock),
    .resetn      (resetn),
    .pix_en      (pix_en),
    .h           (h),
    .v           (v),
    .visible     (visible),
    .hs_n        (hs_n),
    .vs_n        (vs_n),
    .frame_start (frame_start)
  );

  logic [FB_ADDR_W-1:0] row;
  logic [FB_ADDR_W-1:0] col;
  pixel_t               colour;

  // Framebuffer address: row*160 built from two shifts, zero outside the visible area
  always_comb begin
    row = FB_ADDR_W'(v >> H_SCALE_LOG2);
    col = FB_ADDR_W'(h >> H_SCALE_LOG2);
    if (visible && (col < FB_ADDR_W'(FB_WIDTH)))
      fb.fb_addr = (row << 7) + (row << 5) + col;
    else
      fb.fb_addr = '0;
  end

`ifdef SCANOUT_TESTPAT_EN
  logic unused_fb_data;
  assign unused_fb_data = ^fb.fb_data;
  // Colour bars from the horizontal position; RAM data is ignored
  always_comb colour = bar_colour(h);
`else
  // Colour straight from the framebuffer read port
  always_comb colour = fb.fb_data;
`endif

  // Output pipeline: capture colour, sync and blank together on each advance edge
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
    end else if (pix_en) begin
      VGA_HS      <= hs_n;
      VGA_VS      <= vs_n;
      VGA_BLANK_N <= visible;
      VGA_R       <= visible ? {10{colour[2]}} : 10'd0;
      VGA_G       <= visible ? {10{colour[1]}} : 10'd0;
      VGA_B       <= visible ? {10{colour[0]}} : 10'd0;
    end
  end

  assign VGA_CLK    = pix_en;
  assign VGA_SYNC_N = 1'b1;

endmodule
